// File: rtl/inst_decode_q.sv
// inst_decode_q: instruction decode stage feeding a small FIFO of decoded entries.
// Each fetched word is decoded on entry, and the queue stores the decoded
// control fields and immediate next to the raw word. Output latency is one cycle,
// and there is no bypass path around the queue.
// Optional feature macro: INST_DECODE_MULDIV_EN. When it is defined, funct7=0000001
// in R-type ALU ops decodes as multiply/divide. When it is undefined, those words
// are illegal.

package inst_decode_q_pkg;
  typedef enum logic [2:0] {INST_R, INST_I, INST_S, INST_B, INST_U, INST_J, INST_X} itype_e;

  typedef struct packed {
    itype_e     itype;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rwb_en;
    logic       is_lui;
    logic       is_jump;
    logic       is_load;
    logic       is_aluop;
    logic       is_csr;
    logic       is_op32;
    logic       is_muldiv;
  } InstCtrl;
endpackage

module inst_decode_q
  import inst_decode_q_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_addr,
  input  logic [31:0]             in_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_addr,
  output logic [31:0]             out_bits,
  output InstCtrl                 out_ctrl,
  output logic [XLEN-1:0]         out_imm,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Opcode decode. funct3/funct7 are carried through even for illegal words.
  function automatic InstCtrl decode_ctrl(input logic [31:0] b);
    InstCtrl c;
    logic    legal;
    c        = '0;
    c.funct3 = b[14:12];
    c.funct7 = b[31:25];
    legal    = 1'b1;
    case (b[6:0])
      7'b0110111: begin c.itype = INST_U; c.rwb_en = 1'b1; c.is_lui = 1'b1; end
      7'b0010111: begin c.itype = INST_U; c.rwb_en = 1'b1; end
      7'b1101111: begin c.itype = INST_J; c.rwb_en = 1'b1; c.is_jump = 1'b1; end
      7'b1100111: begin c.itype = INST_I; c.rwb_en = 1'b1; c.is_jump = 1'b1; end
      7'b1100011: c.itype = INST_B;
      7'b0000011: begin c.itype = INST_I; c.rwb_en = 1'b1; c.is_load = 1'b1; end
      7'b0100011: c.itype = INST_S;
      7'b0010011: begin c.itype = INST_I; c.rwb_en = 1'b1; c.is_aluop = 1'b1; end
      7'b0110011: begin
        c.itype    = INST_R;
        c.rwb_en   = 1'b1;
        c.is_aluop = 1'b1;
        if (b[31:25] == 7'b0000001) begin
`ifdef INST_DECODE_MULDIV_EN
          c.is_muldiv = 1'b1;
`else
          legal = 1'b0;
`endif
        end
      end
      7'b1110011: begin c.itype = INST_I; c.rwb_en = 1'b1; c.is_csr = 1'b1; end
      7'b0011011: begin
        if (XLEN == 64) begin
          c.itype = INST_I; c.rwb_en = 1'b1; c.is_aluop = 1'b1; c.is_op32 = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          c.itype = INST_R; c.rwb_en = 1'b1; c.is_aluop = 1'b1; c.is_op32 = 1'b1;
          if (b[31:25] == 7'b0000001) begin
`ifdef INST_DECODE_MULDIV_EN
            c.is_muldiv = 1'b1;
`else
            legal = 1'b0;
`endif
          end
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c        = '0;
      c.funct3 = b[14:12];
      c.funct7 = b[31:25];
      c.itype  = INST_X;
    end
    return c;
  endfunction

  // Immediate assembly, sign-extended from bit 31 to XLEN.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] b, input itype_e t);
    logic signed [31:0] i32;
    case (t)
      INST_I:  i32 = {{20{b[31]}}, b[31:20]};
      INST_S:  i32 = {{20{b[31]}}, b[31:25], b[11:7]};
      INST_B:  i32 = {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
      INST_U:  i32 = {b[31:12], 12'b0};
      INST_J:  i32 = {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
      default: i32 = '0;
    endcase
    return XLEN'(i32);
  endfunction

  logic [XLEN-1:0] addr_mem_q [DEPTH];
  logic [31:0]     bits_mem_q [DEPTH];
  InstCtrl         ctrl_mem_q [DEPTH];
  logic [XLEN-1:0] imm_mem_q  [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  InstCtrl         dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            push;
  logic            pop;

  assign dec_ctrl  = decode_ctrl(in_bits);
  assign dec_imm   = decode_imm(in_bits, dec_ctrl.itype);
  assign out_valid = (count_q != '0);
  assign in_ready  = !flush && ((count_q < DEPTH_C) || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Pointer and occupancy next-state; flush wins over any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are never visible while the queue is empty, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      bits_mem_q[wr_ptr_q] <= in_bits;
      ctrl_mem_q[wr_ptr_q] <= dec_ctrl;
      imm_mem_q[wr_ptr_q]  <= dec_imm;
    end
  end

  // Head entry presentation, forced to zero when empty.
  always_comb begin
    out_addr    = '0;
    out_bits    = '0;
    out_ctrl    = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_addr    = addr_mem_q[rd_ptr_q];
      out_bits    = bits_mem_q[rd_ptr_q];
      out_ctrl    = ctrl_mem_q[rd_ptr_q];
      out_imm     = imm_mem_q[rd_ptr_q];
      out_illegal = (ctrl_mem_q[rd_ptr_q].itype == INST_X);
    end
  end

endmodule

// File: tb/tb_inst_decode_q.sv
// Bench for inst_decode_q: XLEN=32/DEPTH=2 instance under a scoreboard, plus an
// XLEN=64 instance for the RV64-only opcodes. Honours INST_DECODE_MULDIV_EN.
module tb_inst_decode_q;
  import inst_decode_q_pkg::*;

`ifdef INST_DECODE_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] bits;
    InstCtrl     ctrl;
    logic [31:0] imm;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_bits;
  InstCtrl     out_ctrl;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [1:0]  count;

  logic        v64 = 1'b0;
  logic        rdy64;
  logic [63:0] addr64 = '0;
  logic [31:0] bits64 = '0;
  logic        ov64;
  logic        ordy64 = 1'b0;
  logic [63:0] oaddr64;
  logic [31:0] obits64;
  InstCtrl     octrl64;
  logic [63:0] oimm64;
  logic        oill64;
  logic [2:0]  cnt64;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  inst_decode_q #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_bits(out_bits),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
  );

  inst_decode_q #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_addr(addr64), .in_bits(bits64),
    .out_valid(ov64), .out_ready(ordy64), .out_addr(oaddr64), .out_bits(obits64),
    .out_ctrl(octrl64), .out_imm(oimm64), .out_illegal(oill64), .count(cnt64)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Reference decode for the XLEN=32 instance.
  function automatic ent_t model(input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    e = '0;
    e.addr = a;
    e.bits = b;
    e.ctrl.funct3 = b[14:12];
    e.ctrl.funct7 = b[31:25];
    e.ctrl.itype  = INST_X;
    case (b[6:0])
      7'h37: begin e.ctrl.itype = INST_U; e.ctrl.rwb_en = 1; e.ctrl.is_lui = 1; end
      7'h17: begin e.ctrl.itype = INST_U; e.ctrl.rwb_en = 1; end
      7'h6F: begin e.ctrl.itype = INST_J; e.ctrl.rwb_en = 1; e.ctrl.is_jump = 1; end
      7'h67: begin e.ctrl.itype = INST_I; e.ctrl.rwb_en = 1; e.ctrl.is_jump = 1; end
      7'h63: e.ctrl.itype = INST_B;
      7'h03: begin e.ctrl.itype = INST_I; e.ctrl.rwb_en = 1; e.ctrl.is_load = 1; end
      7'h23: e.ctrl.itype = INST_S;
      7'h13: begin e.ctrl.itype = INST_I; e.ctrl.rwb_en = 1; e.ctrl.is_aluop = 1; end
      7'h33: begin
        if (b[31:25] != 7'h01 || MULDIV) begin
          e.ctrl.itype = INST_R; e.ctrl.rwb_en = 1; e.ctrl.is_aluop = 1;
          e.ctrl.is_muldiv = (b[31:25] == 7'h01);
        end
      end
      7'h73: begin e.ctrl.itype = INST_I; e.ctrl.rwb_en = 1; e.ctrl.is_csr = 1; end
      default: ;
    endcase
    e.ill = (e.ctrl.itype == INST_X);
    case (e.ctrl.itype)
      INST_I:  e.imm = 32'($signed(b[31:20]));
      INST_S:  e.imm = 32'($signed({b[31:25], b[11:7]}));
      INST_B:  e.imm = 32'($signed({b[31], b[7], b[30:25], b[11:8], 1'b0}));
      INST_U:  e.imm = {b[31:12], 12'h000};
      INST_J:  e.imm = 32'($signed({b[31], b[19:12], b[20], b[30:21], 1'b0}));
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  // One clock: records accepted pushes and hands back any popped entry with its expectation.
  task automatic clk_cycle(output bit popped, output ent_t e, output ent_t o);
    popped = 1'b0;
    e = '0;
    o = '0;
    @(negedge clk);
    if (flush || rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        popped = 1'b1;
        o = '{out_addr, out_bits, out_ctrl, out_imm, out_illegal};
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
      end
      if (in_valid && in_ready) sb.push_back(model(in_addr, in_bits));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_addr !== 32'h0 || out_bits !== 32'h0 || out_imm !== 32'h0)
      begin errors++; $display("FAIL rst_out_data got %h/%h/%h want 0", out_addr, out_bits, out_imm); end
    checks++; if (out_ctrl !== InstCtrl'(0) || out_illegal !== 1'b0)
      begin errors++; $display("FAIL rst_out_ctrl got %h/%b want 0", out_ctrl, out_illegal); end
    checks++; if (cnt64 !== 3'd0 || ov64 !== 1'b0) begin errors++; $display("FAIL rst_dut64 got %0d/%b want 0/0", cnt64, ov64); end
  endtask

  task automatic test_addi();
    bit p; ent_t e, o;
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h8000_0000; in_bits = 32'h0050_0093;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_no_bypass got %b want 0", out_valid); end
    clk_cycle(p, e, o);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (out_ctrl.itype !== INST_I || out_ctrl.rwb_en !== 1'b1 || out_ctrl.is_aluop !== 1'b1)
      begin errors++; $display("FAIL addi_ctrl got %h want itype I rwb aluop", out_ctrl); end
    checks++; if (out_imm !== 32'h0000_0005) begin errors++; $display("FAIL addi_imm got %h want 00000005", out_imm); end
    checks++; if (out_addr !== 32'h8000_0000) begin errors++; $display("FAIL addi_addr got %h want 80000000", out_addr); end
    out_ready = 1'b1;
    clk_cycle(p, e, o);
    if (p) begin checks++; if (o !== e) begin errors++; $display("FAIL addi_pop got %h want %h", o, e); end end
    out_ready = 1'b0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL addi_drain got %0d want 0", count); end
  endtask

  task automatic test_stream();
    logic [31:0] words [12];
    bit p; ent_t e, o;
    int pops = 0;
    words = '{32'h1234_50B7, 32'h0000_1117, 32'h0080_006F, 32'h0000_80E7,
              32'hFE20_8EE3, 32'h0040_A183, 32'h0020_A223, 32'h4020_8033,
              32'h3000_1073, 32'hFFF0_011B, 32'h0000_007F, 32'h8000_0237};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_addr = 32'h1000 + 32'(i * 4); in_bits = words[i];
      clk_cycle(p, e, o);
      if (p) begin pops++; checks++; if (o !== e) begin errors++; $display("FAIL stream_pop%0d got %h want %h", i, o, e); end end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clk_cycle(p, e, o);
      if (p) begin pops++; checks++; if (o !== e) begin errors++; $display("FAIL stream_drain%0d got %h want %h", i, o, e); end end
    end
    out_ready = 1'b0;
    checks++; if (pops !== 12) begin errors++; $display("FAIL stream_pops got %0d want 12", pops); end
  endtask

  task automatic test_full();
    bit p; ent_t e, o;
    int pops = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_addr = 32'hA0; in_bits = 32'h0010_0093; clk_cycle(p, e, o);
    in_addr = 32'hA4; in_bits = 32'h0020_0113; clk_cycle(p, e, o);
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got %0d/%b want 2/0", count, in_ready); end
    in_addr = 32'hA8; in_bits = 32'h0030_0193; clk_cycle(p, e, o);
    checks++; if (count !== 2'd2 || out_addr !== 32'hA0) begin errors++; $display("FAIL full_hold got %0d/%h want 2/a0", count, out_addr); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_ready got %b want 1", in_ready); end
    clk_cycle(p, e, o);
    if (p) begin pops++; checks++; if (o !== e) begin errors++; $display("FAIL full_pop0 got %h want %h", o, e); end end
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_pushpop_count got %0d want 2", count); end
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      clk_cycle(p, e, o);
      if (p) begin pops++; checks++; if (o !== e) begin errors++; $display("FAIL full_pop%0d got %h want %h", i, o, e); end end
    end
    out_ready = 1'b0;
    checks++; if (count !== 2'd0 || pops !== 3) begin errors++; $display("FAIL full_drain got %0d/%0d want 0/3", count, pops); end
  endtask

  task automatic test_flush();
    bit p; ent_t e, o;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_addr = 32'hB0; in_bits = 32'h0000_0013; clk_cycle(p, e, o);
    in_addr = 32'hB4; in_bits = 32'h0000_0013; clk_cycle(p, e, o);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", count); end
    flush = 1'b1; out_ready = 1'b1; in_addr = 32'hB8;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    clk_cycle(p, e, o);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_addr !== 32'h0)
      begin errors++; $display("FAIL flush_empty got %0d/%b/%h want 0/0/0", count, out_valid, out_addr); end
    clk_cycle(p, e, o);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_no_accept got %0d want 0", count); end
  endtask

  task automatic test_muldiv_illegal();
    bit p; ent_t e, o;
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'hC0; in_bits = 32'h0220_8033;
    clk_cycle(p, e, o);
    in_valid = 1'b0;
    checks++; if (out_illegal !== !MULDIV || out_ctrl.is_muldiv !== MULDIV)
      begin errors++; $display("FAIL mul_decode got ill=%b md=%b want ill=%b md=%b", out_illegal, out_ctrl.is_muldiv, !MULDIV, MULDIV); end
    out_ready = 1'b1; in_valid = 1'b1; in_addr = 32'hC4; in_bits = 32'hFFF0_011B;
    clk_cycle(p, e, o);
    if (p) begin checks++; if (o !== e) begin errors++; $display("FAIL mul_pop got %h want %h", o, e); end end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_illegal !== 1'b1 || out_ctrl.itype !== INST_X || out_imm !== 32'h0)
      begin errors++; $display("FAIL addiw32_illegal got %b/%0d/%h want 1/X/0", out_illegal, out_ctrl.itype, out_imm); end
    out_ready = 1'b1;
    clk_cycle(p, e, o);
    if (p) begin checks++; if (o !== e) begin errors++; $display("FAIL addiw32_pop got %h want %h", o, e); end end
    out_ready = 1'b0;
  endtask

  task automatic test_xlen64();
    ordy64 = 1'b0;
    v64 = 1'b1; addr64 = 64'h0000_0001_0000_0000; bits64 = 32'hFFF0_011B;
    @(posedge clk); #1;
    v64 = 1'b0;
    checks++; if (ov64 !== 1'b1 || octrl64.itype !== INST_I || octrl64.is_op32 !== 1'b1 || octrl64.is_aluop !== 1'b1 || octrl64.rwb_en !== 1'b1)
      begin errors++; $display("FAIL addiw64_ctrl got %b/%h want valid I op32", ov64, octrl64); end
    checks++; if (oimm64 !== 64'hFFFF_FFFF_FFFF_FFFF || oill64 !== 1'b0 || oaddr64 !== 64'h0000_0001_0000_0000)
      begin errors++; $display("FAIL addiw64_data got %h/%b/%h want ffffffffffffffff/0/100000000", oimm64, oill64, oaddr64); end
    ordy64 = 1'b1; v64 = 1'b1; bits64 = 32'h0220_803B;
    @(posedge clk); #1;
    v64 = 1'b0; ordy64 = 1'b0;
    checks++; if (cnt64 !== 3'd1 || oill64 !== !MULDIV || octrl64.is_muldiv !== MULDIV || octrl64.is_op32 !== MULDIV)
      begin errors++; $display("FAIL mulw64 got cnt=%0d ill=%b md=%b op32=%b want 1/%b/%b/%b", cnt64, oill64, octrl64.is_muldiv, octrl64.is_op32, !MULDIV, MULDIV, MULDIV); end
    ordy64 = 1'b1;
    @(posedge clk); #1;
    ordy64 = 1'b0;
    checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL drain64 got %b want 0", ov64); end
  endtask

  task automatic test_async_reset();
    bit p; ent_t e, o;
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'hD0; in_bits = 32'h0000_0013;
    clk_cycle(p, e, o);
    in_valid = 1'b0;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL areset_pre got %0d want 1", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL areset_async got %b/%0d want 0/0", out_valid, count); end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_release got %b/%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stream();
    test_full();
    test_flush();
    test_muldiv_illegal();
    test_xlen64();
    test_async_reset();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_decode_q.md
INST_DECODE_Q -- requirements
Module: inst_decode_q

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-entry queue depth; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all queued entries.
REQ-006 SHALL have port in_valid  input  1  fetched instruction present.
REQ-007 SHALL have port in_ready  output  1  queue accepts instruction.
REQ-008 SHALL have port in_addr  input  XLEN  instruction address.
REQ-009 SHALL have port in_bits  input  32  raw instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-012 SHALL have port out_addr  output  XLEN  head address.
REQ-013 SHALL have port out_bits  output  32  head raw word.
REQ-014 SHALL have port out_ctrl  output  InstCtrl  head decoded control struct.
REQ-015 SHALL have port out_imm  output  XLEN  head immediate, sign-extended.
REQ-016 SHALL have port out_illegal  output  1  head opcode not decodable.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL decode in_bits combinationally at push time and store decoded fields, not raw-only, in the queue.
REQ-019 SHALL decode opcode: 0110111 U rwb_en,is_lui; 0010111 U rwb_en; 1101111 J rwb_en,is_jump; 1100111 I rwb_en,is_jump; 1100011 B; 0000011 I rwb_en,is_load; 0100011 S; 0010011 I rwb_en,is_aluop; 0110011 R rwb_en,is_aluop; 1110011 I rwb_en,is_csr.
REQ-020 SHALL decode 0011011 (I) and 0111011 (R) as rwb_en,is_aluop,is_op32 when XLEN=64; illegal when XLEN=32.
REQ-021 SHALL mark any other opcode illegal: itype INST_X, all flags 0, out_illegal 1.
REQ-022 SHALL copy funct3=bits[14:12], funct7=bits[31:25] for every opcode.
REQ-023 SHALL form imm per itype (I,S,B,U,J standard RISC-V) sign-extended from bit 31 to XLEN; R/X imm = 0; U imm = {bits[31:12],12'b0} sign-extended.
REQ-024 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-025 SHALL drive in_ready = (count < DEPTH) || out_ready (push allowed on full with simultaneous pop), and in_ready = 0 while flush=1.
REQ-026 SHALL drive out_valid = (count != 0); out_* from head entry, zero when empty.
REQ-027 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-028 SHALL, on flush=1, set count and both pointers to 0 next edge, ignoring same-cycle push and pop.
REQ-029 SHALL give 1-cycle latency: entry pushed at edge N is visible on out_* after edge N, empty-queue case included (no bypass).
REQ-030 SHALL hold head outputs stable while out_valid && !out_ready.

Reset
REQ-031 SHALL on rst=1 immediately clear count, read and write pointers to 0; out_valid=0, out_* = 0, in_ready=1 after release.
REQ-032 SHALL not require clearing queue storage on reset; storage is unobservable while count=0.
REQ-033 SHALL abort any in-flight push/pop when rst asserts mid-operation; no entry survives reset.

Configuration
REQ-034 SHALL use macro INST_DECODE_MULDIV_EN.
REQ-035 With INST_DECODE_MULDIV_EN defined: opcodes 0110011/0111011 with funct7=0000001 set is_muldiv=1 in addition to REQ-019/020 flags.
REQ-036 Without INST_DECODE_MULDIV_EN: those encodings SHALL be illegal (INST_X, flags 0, out_illegal 1).

Verification
REQ-037 XLEN=32, push 0x00500093 at 0x80000000 -> next cycle out_valid=1, itype INST_I, rwb_en=1, is_aluop=1, imm=0x00000005, out_addr=0x80000000.
REQ-038 XLEN=64, push 0xFFF0011B (ADDIW) -> is_op32=1, imm=0xFFFFFFFFFFFFFFFF; same word at XLEN=32 -> out_illegal=1, itype INST_X.
REQ-039 DEPTH=2, push 3 words with out_ready=0 -> count=2, in_ready=0; raise out_ready with in_valid -> push+pop same cycle, count stays 2, order preserved.
REQ-040 Queue holding 2 entries, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, no entry accepted.
REQ-041 Push 0x02208033 (MUL) -> with INST_DECODE_MULDIV_EN is_muldiv=1, out_illegal=0; without it out_illegal=1.
REQ-042 Assert rst asynchronously mid-cycle with count=1 -> out_valid=0 and count=0 before next clk edge.
